flt2int_engine: RTL

Parametrised, self-sequencing float-to-integer converter that replaces the software conversion loop with a hardware FSM. On `start`, it walks `N_WORDS` packed floats in data memory, converts each to a truncated two's-complement integer with saturation, writes the results back, and counts the saturated words. It sits beside the processor top and shares a single byte-wide port into `data_mem`. While it runs, it owns that port, and `done` reports completion to the test harness.

---
 rtl/flt2int_pkg.sv | 27 ++
 rtl/flt2int_engine_core.sv | 55 +++++
 rtl/flt2int_engine.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/flt2int_pkg.sv
// flt2int_pkg: shared types and constants for the float-to-integer engine.
//   cvt_state_t     - engine sequencing states
//   BIAS()          - exponent bias for a given exponent width
//   INT_MAX/INT_MIN - saturation values for the 16-bit result
package flt2int_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_HI = 3'd1,
        S_RD_LO = 3'd2,
        S_CAP   = 3'd3,
        S_CONV  = 3'd4,
        S_WR_HI = 3'd5,
        S_WR_LO = 3'd6,
        S_DONE  = 3'd7
    } cvt_state_t;

    localparam int unsigned INT_W_DEF = 16;
    localparam logic [INT_W_DEF-1:0] INT_MAX = 16'h7FFF;
    localparam logic [INT_W_DEF-1:0] INT_MIN = 16'h8000;

    // Exponent bias: 2^(exp_w-1) - 1
    function automatic int unsigned BIAS(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/flt2int_engine_core.sv
// flt_to_int_core: combinational packed-float to two's-complement integer
// conversion, truncating toward zero and saturating out-of-range values.
//   i_s, i_e, i_m - sign, biased exponent, mantissa
//   o_result_c    - converted integer
//   o_sat_c       - high when the result was clamped
module flt_to_int_core
    import flt2int_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    parameter int unsigned INT_W = 16
) (
    input  logic             i_s,
    input  logic [EXP_W-1:0] i_e,
    input  logic [MAN_W-1:0] i_m,
    output logic [INT_W-1:0] o_result_c,
    output logic             o_sat_c
);

    // Wide enough that neither shift direction can lose significant bits
    localparam int unsigned SH_W   = INT_W + MAN_W;
    localparam int unsigned BIAS_V = BIAS(EXP_W);
    localparam int unsigned E_SAT  = BIAS_V + INT_W - 1;
    localparam logic [INT_W-1:0] L_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] L_MIN = {1'b1, {(INT_W-1){1'b0}}};

    logic [SH_W-1:0] w_mag;
    int unsigned     w_exp;

    always_comb begin
        w_exp      = 32'(i_e);
        w_mag      = SH_W'({1'b1, i_m});
        o_sat_c    = 1'b0;
        o_result_c = '0;
        if (i_e == '0 || w_exp < BIAS_V) begin
            o_result_c = '0;
        end else if (i_e == '1 || w_exp >= E_SAT) begin
            // -2^(INT_W-1) is representable exactly, so it is not a saturation
            if (i_s && i_m == '0 && w_exp == E_SAT && i_e != '1) begin
                o_result_c = L_MIN;
            end else begin
                o_sat_c    = 1'b1;
                o_result_c = i_s ? L_MIN : L_MAX;
            end
        end else begin
            if ((w_exp - BIAS_V) <= MAN_W) begin
                w_mag = w_mag >> (MAN_W - (w_exp - BIAS_V));
            end else begin
                w_mag = w_mag << ((w_exp - BIAS_V) - MAN_W);
            end
            o_result_c = i_s ? INT_W'(-w_mag) : INT_W'(w_mag);
        end
    end

endmodule

// File: rtl/flt2int_engine.sv
// flt2int_engine: walks N_WORDS packed floats in byte-wide data memory,
// converts each to a saturated integer and writes the results back.
//   clk, reset (sync, active-low), start     - control
//   busy, done                               - run status
//   mem_addr, mem_rd, mem_wr, mem_wdata      - memory port (rdata one cycle after rd)
//   mem_rdata                                - read data
//   sat_cnt                                  - saturated words in the last run
module flt2int_engine
    import flt2int_pkg::*;
#(
    parameter int unsigned N_WORDS  = 15,
    parameter int unsigned EXP_W    = 5,
    parameter int unsigned MAN_W    = 10,
    parameter int unsigned INT_W    = 16,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 30,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic                             mem_rd,
    output logic                             mem_wr,
    output logic [7:0]                       mem_wdata,
    input  logic [7:0]                       mem_rdata,
    output logic [$clog2(N_WORDS+1)-1:0]     sat_cnt
);

    localparam int unsigned CNT_W = $clog2(N_WORDS + 1);
    localparam int unsigned FLT_W = 1 + EXP_W + MAN_W;

    cvt_state_t        r_state;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_sat_cnt;
    logic [7:0]        r_hi;
    logic [7:0]        r_lo;
    logic [7:0]        r_res_lo;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

    logic [FLT_W-1:0]  w_flt;
    logic [INT_W-1:0]  w_result;
    logic              w_sat;
    logic [CNT_W-1:0]  w_idx_nxt;
    logic [ADDR_W-1:0] w_src_nxt;
    logic [ADDR_W-1:0] w_dst_hi;
    logic              w_last;

    assign w_flt     = {r_hi, r_lo};
    assign w_idx_nxt = r_idx + CNT_W'(1);
    assign w_src_nxt = ADDR_W'(SRC_BASE) + ADDR_W'({w_idx_nxt, 1'b0});
    assign w_dst_hi  = ADDR_W'(DST_BASE) + ADDR_W'({r_idx, 1'b0});
    assign w_last    = (r_idx == CNT_W'(N_WORDS - 1));

    flt_to_int_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .INT_W (INT_W)
    ) u_core (
        .i_s        (w_flt[FLT_W-1]),
        .i_e        (w_flt[FLT_W-2 -: EXP_W]),
        .i_m        (w_flt[MAN_W-1:0]),
        .o_result_c (w_result),
        .o_sat_c    (w_sat)
    );

    // Sequencer: memory strobes/addresses are registered on entry to each state
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_sat_cnt   <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_res_lo    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_idx      <= '0;
                        r_sat_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= ADDR_W'(SRC_BASE);
                        r_state    <= S_RD_HI;
                    end else if (r_state == S_DONE) begin
                        r_done <= 1'b1;
                    end
                end
                S_RD_HI: begin
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    r_state    <= S_RD_LO;
                end
                S_RD_LO: begin
                    r_hi    <= mem_rdata;
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    r_lo    <= mem_rdata;
                    r_state <= S_CONV;
                end
                S_CONV: begin
                    r_res_lo    <= w_result[7:0];
                    r_mem_wdata <= w_result[INT_W-1 -: 8];
                    r_mem_wr    <= 1'b1;
                    r_mem_addr  <= w_dst_hi;
                    if (w_sat) begin
                        r_sat_cnt <= r_sat_cnt + CNT_W'(1);
                    end
                    r_state <= S_WR_HI;
                end
                S_WR_HI: begin
                    r_mem_wr    <= 1'b1;
                    r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                    r_mem_wdata <= r_res_lo;
                    r_state     <= S_WR_LO;
                end
                S_WR_LO: begin
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx      <= w_idx_nxt;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_src_nxt;
                        r_state    <= S_RD_HI;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wdata;
    assign sat_cnt   = r_sat_cnt;

endmodule
